// File: rtl/syscall_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : syscall_responder_if                                          |
// | Purpose  : Bundles the three handshake buses of the syscall responder:   |
// |            the request channel from EX, the byte-read channel used for   |
// |            string fetch, and the outgoing character stream.              |
// | Signals  : req_valid/req_ready/req_v0/req_a0  - syscall request          |
// |            mem_req/mem_addr/mem_ack/mem_rdata - string byte fetch        |
// |            char_valid/char_data/char_ready   - character stream          |
// | Modports : slave  - the responder                                        |
// |            master - the environment (EX stage, memory, char consumer)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface syscall_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_v0;
  logic [31:0] req_a0;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;

  modport slave (
    input  req_valid, req_v0, req_a0,
    output req_ready,
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output char_valid, char_data,
    input  char_ready
  );

  modport master (
    output req_valid, req_v0, req_a0,
    input  req_ready,
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  char_valid, char_data,
    output char_ready
  );
endinterface
`default_nettype wire

// File: rtl/syscall_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : syscall_responder                                             |
// | Purpose  : Executes syscalls issued from the EX stage: print int to the  |
// |            display register, print char / print string into a char      |
// |            FIFO, exit into a sticky halt. Scans the display register     |
// |            onto an 8-digit multiplexed seven-segment display.            |
// | Ports    : clk, clr_n (async active-low reset)                           |
// |            bus            - request / memory / char-stream buses         |
// |            display_value  - last printed integer                         |
// |            halt           - sticky exit flag                             |
// |            pc_inc_mask    - 2'b11 while halted                           |
// |            bad_syscall    - 1-cycle pulse on an unsupported code         |
// |            seg_an/seg_cat - active-low digit enables and segments {g..a} |
// |            stat_count     - accepted-request count                       |
// | Options  : define SYSCALL_STATS_EN to build the saturating request       |
// |            counter; otherwise stat_count is tied to zero.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module syscall_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int STR_MAX    = 256
) (
  input  wire logic               clk,
  input  wire logic               clr_n,
  syscall_responder_if.slave      bus,
  output logic [31:0]             display_value,
  output logic                    halt,
  output logic [1:0]              pc_inc_mask,
  output logic                    bad_syscall,
  output logic [7:0]              seg_an,
  output logic [6:0]              seg_cat,
  output logic [15:0]             stat_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LEN_W  = $clog2(STR_MAX + 1);

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STR_REQ  = 2'd1,
    S_STR_WAIT = 2'd2,
    S_HALTED   = 2'd3
  } state_e;

  state_e            state_q;
  logic [31:0]       display_q;
  logic              halt_q;
  logic              bad_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       ptr_q;
  logic [LEN_W-1:0]  len_q;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [2:0]        digit_q;

  logic fifo_full, fifo_empty, req_ready, accept;
  logic str_ack, str_end, push, push_ok, pop;
  logic [7:0] push_data;
  logic [3:0] nibble;

  // ---------------------------------------------------------------- control
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign req_ready  = (state_q == S_IDLE) && !halt_q && !fifo_full;
  assign accept     = bus.req_valid && req_ready;

  // A NUL byte or the length limit ends the string; the terminating byte is
  // never queued.
  assign str_ack = (state_q == S_STR_WAIT) && bus.mem_ack;
  assign str_end = (bus.mem_rdata == 8'h00) || (len_q == LEN_W'(STR_MAX - 1));

  assign push      = (accept && (bus.req_v0 == SYS_PRINT_CHAR)) || (str_ack && !str_end);
  assign push_data = (state_q == S_IDLE) ? bus.req_a0[7:0] : bus.mem_rdata;
  assign pop       = !fifo_empty && bus.char_ready;
  // Both push sources are already gated by !fifo_full; the pop term keeps
  // the FIFO itself correct for a push-while-full with a concurrent pop.
  assign push_ok   = push && (!fifo_full || pop);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      display_q  <= 32'h0;
      halt_q     <= 1'b0;
      bad_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      ptr_q      <= 32'h0;
      len_q      <= '0;
    end else begin
      bad_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (bus.req_v0)
              SYS_PRINT_INT:  display_q <= bus.req_a0;
              SYS_PRINT_CHAR: ; // handled by the FIFO push path
              SYS_PRINT_STR: begin
                ptr_q   <= bus.req_a0;
                len_q   <= '0;
                state_q <= S_STR_REQ;
              end
              SYS_EXIT: begin
                halt_q  <= 1'b1;
                state_q <= S_HALTED;
              end
              default:        bad_q <= 1'b1;
            endcase
          end
        end
        S_STR_REQ: begin
          // Only fetch when there is room, so the ack can always push.
          if (!fifo_full) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= ptr_q;
            state_q    <= S_STR_WAIT;
          end
        end
        S_STR_WAIT: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (str_end) begin
              state_q <= S_IDLE;
            end else begin
              ptr_q   <= ptr_q + 32'd1;
              len_q   <= len_q + LEN_W'(1);
              state_q <= S_STR_REQ;
            end
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ----------------------------------------------------------- display scan
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      scan_cnt_q <= '0;
      digit_q    <= 3'd0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      digit_q    <= digit_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  assign nibble = display_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    seg_cat = 7'b1111111;
    case (nibble)
      4'h0: seg_cat = 7'b1000000;
      4'h1: seg_cat = 7'b1111001;
      4'h2: seg_cat = 7'b0100100;
      4'h3: seg_cat = 7'b0110000;
      4'h4: seg_cat = 7'b0011001;
      4'h5: seg_cat = 7'b0010010;
      4'h6: seg_cat = 7'b0000010;
      4'h7: seg_cat = 7'b1111000;
      4'h8: seg_cat = 7'b0000000;
      4'h9: seg_cat = 7'b0010000;
      4'hA: seg_cat = 7'b0001000;
      4'hB: seg_cat = 7'b0000011;
      4'hC: seg_cat = 7'b1000110;
      4'hD: seg_cat = 7'b0100001;
      4'hE: seg_cat = 7'b0000110;
      4'hF: seg_cat = 7'b0001110;
      default: seg_cat = 7'b1111111;
    endcase
  end

  assign seg_an = ~(8'b0000_0001 << digit_q);

  // ------------------------------------------------------------- statistics
`ifdef SYSCALL_STATS_EN
  logic [15:0] stat_q;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stat_q <= 16'h0;
    end else if (accept && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end
  assign stat_count = stat_q;
`else
  assign stat_count = 16'h0;
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.req_ready  = req_ready;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.char_valid = !fifo_empty;
  // Hold the stream data at zero while empty so it never shows stale bytes.
  assign bus.char_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign display_value  = display_q;
  assign halt           = halt_q;
  assign pc_inc_mask    = {halt_q, halt_q};
  assign bad_syscall    = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_syscall_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_syscall_responder                                          |
// | Purpose  : Directed self-checking bench for syscall_responder.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_syscall_responder;

  localparam int SCAN = 4;

  logic        clk;
  logic        clr_n;
  logic [31:0] display_value;
  logic        halt;
  logic [1:0]  pc_inc_mask;
  logic        bad_syscall;
  logic [7:0]  seg_an;
  logic [6:0]  seg_cat;
  logic [15:0] stat_count;

  syscall_responder_if ifc();

  syscall_responder #(
    .FIFO_DEPTH(8),
    .SCAN_DIV  (SCAN),
    .STR_MAX   (256)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .bus          (ifc),
    .display_value(display_value),
    .halt         (halt),
    .pc_inc_mask  (pc_inc_mask),
    .bad_syscall  (bad_syscall),
    .seg_an       (seg_an),
    .seg_cat      (seg_cat),
    .stat_count   (stat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;  // clock edges since reset release; drives the scan model

  always @(posedge clk) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ------------------------------------------------------- memory responder
  logic [7:0]  mem_bytes [logic [31:0]];
  logic [31:0] addr_log [$];
  int          lat;

  initial begin
    ifc.mem_ack   = 1'b0;
    ifc.mem_rdata = 8'h00;
    lat = 0;
    forever begin
      @(posedge clk);
      #3;
      if (!clr_n) begin
        ifc.mem_ack = 1'b0;
        lat = 0;
      end else if (ifc.mem_ack) begin
        ifc.mem_ack = 1'b0;
        lat = 0;
      end else if (ifc.mem_req) begin
        lat++;
        if (lat == 2) begin
          ifc.mem_ack   = 1'b1;
          ifc.mem_rdata = mem_bytes.exists(ifc.mem_addr) ? mem_bytes[ifc.mem_addr] : 8'h00;
          addr_log.push_back(ifc.mem_addr);
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] v0, input logic [31:0] a0);
    ifc.req_valid = 1'b1;
    ifc.req_v0    = v0;
    ifc.req_a0    = a0;
    step();
    ifc.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] dv;
    logic [6:0]  idx0_glyph;
    int          idx;

    n_checks = 0;
    n_errors = 0;
    clr_n = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.req_v0     = 32'h0;
    ifc.req_a0     = 32'h0;
    ifc.char_ready = 1'b0;
    mem_bytes[32'h100] = 8'h48;  // 'H'
    mem_bytes[32'h101] = 8'h69;  // 'i'
    mem_bytes[32'h102] = 8'h00;
    mem_bytes[32'h200] = 8'h58;  // 'X'
    mem_bytes[32'h201] = 8'h00;

    // Reset values
    repeat (3) step();
    check("rst_display", display_value, 32'h0);
    check("rst_halt",    {31'h0, halt}, 32'h0);
    check("rst_mask",    {30'h0, pc_inc_mask}, 32'h0);
    check("rst_bad",     {31'h0, bad_syscall}, 32'h0);
    check("rst_seg_an",  {24'h0, seg_an}, 32'hFE);
    check("rst_seg_cat", {25'h0, seg_cat}, 32'h40);
    check("rst_mem_req", {31'h0, ifc.mem_req}, 32'h0);
    check("rst_cvalid",  {31'h0, ifc.char_valid}, 32'h0);
    check("rst_stat",    {16'h0, stat_count}, 32'h0);
    clr_n = 1'b1;
    step();
    check("idle_ready", {31'h0, ifc.req_ready}, 32'h1);

    // Print int and display scan
    dv = 32'h1234ABCD;
    do_req(32'd1, dv);
    check("pint_value", display_value, dv);
    check("pint_nobad", {31'h0, bad_syscall}, 32'h0);
    idx0_glyph = 7'h7F;
    for (int c = 0; c < 8 * SCAN; c++) begin
      idx = (cyc / SCAN) % 8;
      check("scan_an",  {24'h0, seg_an}, {24'h0, ~(8'h01 << idx)});
      check("scan_cat", {25'h0, seg_cat}, {25'h0, glyph(dv[4*idx +: 4])});
      if (idx == 0) idx0_glyph = seg_cat;
      step();
    end
    check("scan_idx0_D", {25'h0, idx0_glyph}, 32'h21);

    // Unsupported code
    do_req(32'd7, 32'hDEAD);
    check("bad_pulse", {31'h0, bad_syscall}, 32'h1);
    check("bad_keep_disp", display_value, dv);
`ifdef SYSCALL_STATS_EN
    check("bad_stat", {16'h0, stat_count}, 32'd2);
`else
    check("bad_stat", {16'h0, stat_count}, 32'd0);
`endif
    step();
    check("bad_one_cycle", {31'h0, bad_syscall}, 32'h0);

    // Fill the FIFO with the consumer stalled
    for (int i = 0; i < 8; i++) do_req(32'd11, 32'h41 + i);
    check("fifo_full_ready", {31'h0, ifc.req_ready}, 32'h0);
    check("fifo_head", {24'h0, ifc.char_data}, 32'h41);
    ifc.req_valid = 1'b1;  // 9th request must stall while full
    ifc.req_v0    = 32'd11;
    ifc.req_a0    = 32'h5A;
    repeat (3) step();
    ifc.req_valid  = 1'b0;
    ifc.char_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", {31'h0, ifc.char_valid}, 32'h1);
      check("drain_data", {24'h0, ifc.char_data}, 32'h41 + k);
      step();
    end
    check("drain_empty", {31'h0, ifc.char_valid}, 32'h0);
    check("drain_ready", {31'h0, ifc.req_ready}, 32'h1);
    ifc.char_ready = 1'b0;
    do_req(32'd11, 32'h49);
    check("ninth_data", {24'h0, ifc.char_data}, 32'h49);
    ifc.char_ready = 1'b1;
    step();
    check("ninth_popped", {31'h0, ifc.char_valid}, 32'h0);
    ifc.char_ready = 1'b0;
`ifdef SYSCALL_STATS_EN
    check("fifo_stat", {16'h0, stat_count}, 32'd11);
`else
    check("fifo_stat", {16'h0, stat_count}, 32'd0);
`endif

    // Print string "Hi"
    addr_log.delete();
    do_req(32'd4, 32'h100);
    for (int i = 0; i < 60 && !ifc.req_ready; i++) step();
    check("str_done", {31'h0, ifc.req_ready}, 32'h1);
    check("str_nfetch", addr_log.size(), 32'd3);
    if (addr_log.size() == 3) begin
      check("str_addr0", addr_log[0], 32'h100);
      check("str_addr1", addr_log[1], 32'h101);
      check("str_addr2", addr_log[2], 32'h102);
    end
    check("str_memreq_low", {31'h0, ifc.mem_req}, 32'h0);
    check("str_c0", {24'h0, ifc.char_data}, 32'h48);
    ifc.char_ready = 1'b1;
    step();
    check("str_c1", {24'h0, ifc.char_data}, 32'h69);
    step();
    check("str_empty", {31'h0, ifc.char_valid}, 32'h0);
    ifc.char_ready = 1'b0;

    // Reset during a string fetch
    do_req(32'd11, 32'h5A);
    do_req(32'd4, 32'h200);
    for (int i = 0; i < 10 && !ifc.mem_req; i++) step();
    check("mid_memreq", {31'h0, ifc.mem_req}, 32'h1);
    clr_n = 1'b0;
    #1;
    check("mid_rst_memreq", {31'h0, ifc.mem_req}, 32'h0);
    check("mid_rst_fifo", {31'h0, ifc.char_valid}, 32'h0);
    check("mid_rst_disp", display_value, 32'h0);
    step();
    clr_n = 1'b1;
    step();
    check("mid_idle", {31'h0, ifc.req_ready}, 32'h1);
    check("mid_memreq_low", {31'h0, ifc.mem_req}, 32'h0);

    // Exit
    do_req(32'd1, 32'h55);
    do_req(32'd11, 32'h51);
    do_req(32'd10, 32'h0);
    check("halt_flag", {31'h0, halt}, 32'h1);
    check("halt_mask", {30'h0, pc_inc_mask}, 32'h3);
    check("halt_ready", {31'h0, ifc.req_ready}, 32'h0);
    ifc.req_valid = 1'b1;
    ifc.req_v0    = 32'd1;
    ifc.req_a0    = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_nobad", {31'h0, bad_syscall}, 32'h0);
    end
    ifc.req_valid = 1'b0;
    check("halt_ignored", display_value, 32'h55);
    check("halt_fifo_has", {31'h0, ifc.char_valid}, 32'h1);
    ifc.char_ready = 1'b1;
    step();
    check("halt_drained", {31'h0, ifc.char_valid}, 32'h0);
    check("halt_sticky", {31'h0, halt}, 32'h1);
    ifc.char_ready = 1'b0;
    clr_n = 1'b0;
    #1;
    check("clr_halt", {31'h0, halt}, 32'h0);
    check("clr_mask", {30'h0, pc_inc_mask}, 32'h0);
    check("clr_disp", display_value, 32'h0);
    check("clr_seg_an", {24'h0, seg_an}, 32'hFE);
    check("clr_seg_cat", {25'h0, seg_cat}, 32'h40);
    check("clr_stat", {16'h0, stat_count}, 32'h0);
    step();
    clr_n = 1'b1;
    step();
    check("clr_ready", {31'h0, ifc.req_ready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
